// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: in-order EX->WB buffer feeding the GPR write port; owns CR0 and XER OV/SO, updated at retire.
module alu_writeback_stage #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_overflow,
    input  logic                      in_zero,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_reg_write,
    input  logic                      in_rc,
    input  logic                      in_oe,
    input  logic                      flush,
    input  logic                      so_clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_we,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [3:0]                cr0,
    output logic                      xer_ov,
    output logic                      xer_so
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + REG_ADDR_WIDTH + 5;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic push, pop, so_nx;
    logic [DATA_WIDTH-1:0] h_data;
    logic [REG_ADDR_WIDTH-1:0] h_rd;
    logic h_we, h_ov, h_zero, h_rc, h_oe;
    assign push = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    assign out_valid = count != '0;
    assign {h_data, h_rd, h_we, h_ov, h_zero, h_rc, h_oe} = mem[rd_ptr];
    // Head fields are masked when empty so the idle outputs read as zero.
    assign out_data = out_valid ? h_data : '0;
    assign out_rd = out_valid ? h_rd : '0;
    assign out_we = out_valid & h_we;
    always_comb begin
        count_nx = flush ? '0 : count + CW'(push) - CW'(pop);
        so_nx = (pop & h_oe) ? (xer_so | h_ov) : so_clear ? 1'b0 : xer_so;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            in_ready <= 1'b1;
            cr0 <= 4'b0000;
            xer_ov <= 1'b0;
            xer_so <= 1'b0;
        end else begin
            count <= count_nx;
            in_ready <= count_nx < FULL;
            wr_ptr <= flush ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= flush ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
            xer_ov <= (pop & h_oe) ? h_ov : so_clear ? 1'b0 : xer_ov;
            xer_so <= so_nx;
            if (pop && h_rc)
                cr0 <= {h_data[DATA_WIDTH-1], ~h_data[DATA_WIDTH-1] & ~h_zero, h_zero, so_nx};
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= {in_result, in_rd, in_reg_write, in_overflow, in_zero, in_rc, in_oe};
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed vectors with a queue scoreboard checking retire order and CR0/XER updates.
module tb_alu_writeback_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [63:0] in_result = '0;
    logic in_overflow = 1'b0, in_zero = 1'b0;
    logic [4:0] in_rd = '0;
    logic in_reg_write = 1'b0, in_rc = 1'b0, in_oe = 1'b0;
    logic flush = 1'b0, so_clear = 1'b0;
    logic out_valid, out_ready = 1'b0, out_we;
    logic [4:0] out_rd;
    logic [63:0] out_data;
    logic [3:0] cr0;
    logic xer_ov, xer_so;
    logic [69:0] exp_q[$];
    int total = 0;
    int bad = 0;

    alu_writeback_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_overflow(in_overflow), .in_zero(in_zero),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_rc(in_rc), .in_oe(in_oe),
        .flush(flush), .so_clear(so_clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_we(out_we), .out_rd(out_rd), .out_data(out_data), .cr0(cr0),
        .xer_ov(xer_ov), .xer_so(xer_so)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d, input logic ov, input logic z, input logic [4:0] rd,
                        input logic we, input logic rc, input logic oe);
        int n;
        in_result = d; in_overflow = ov; in_zero = z; in_rd = rd;
        in_reg_write = we; in_rc = rc; in_oe = oe; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout rd=%0d in_ready=%b expected=1", rd, in_ready);
        end else begin
            exp_q.push_back({rd, we, d});
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    // Monitor: every accepted head beat must match the oldest outstanding push.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL retire_unexpected got rd=%0d data=%h expected=none", out_rd, out_data);
            end else begin
                chk("retire", {2'b0, out_rd, out_we, out_data}, {2'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        rst = 1'b0;
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_in_ready", 72'(in_ready), 72'd1);
        chk("rst_cr0", 72'(cr0), 72'd0);
        chk("rst_xer", 72'({xer_ov, xer_so}), 72'd0);
        chk("rst_out_data", 72'({out_we, out_rd, out_data}), 72'd0);
        // 1: simple record-form add
        out_ready = 1'b1;
        send(64'h5, 0, 0, 5'd3, 1, 1, 0);
        chk("t1_visible", 72'(out_valid), 72'd1);
        tick(1);
        chk("t1_cr0", 72'(cr0), 72'b0100);
        chk("t1_xer", 72'({xer_ov, xer_so}), 72'd0);
        // 2: overflow sets OV/SO; a clean OE op clears OV only
        send(64'h8000_0000_0000_0000, 1, 0, 5'd4, 1, 1, 1);
        tick(1);
        chk("t2_xer_a", 72'({xer_ov, xer_so}), 72'b11);
        chk("t2_cr0", 72'(cr0), 72'b1001);
        send(64'h7, 0, 0, 5'd5, 0, 0, 1);
        tick(1);
        chk("t2_xer_b", 72'({xer_ov, xer_so}), 72'b01);
        chk("t2_cr0_hold", 72'(cr0), 72'b1001);
        // 3: back-pressure fills the buffer, then drains in order
        out_ready = 1'b0;
        send(64'hA, 0, 0, 5'd6, 1, 0, 0);
        send(64'hB, 0, 0, 5'd7, 1, 0, 0);
        fork
            send(64'hC, 0, 0, 5'd8, 1, 0, 0);
            begin
                tick(3);
                chk("t3_full", 72'(in_ready), 72'd0);
                chk("t3_hold", 72'({out_rd, out_data}), 72'({5'd6, 64'hA}));
                out_ready = 1'b1;
            end
        join
        tick(1);
        chk("t3_drained", 72'(out_valid), 72'd0);
        // 4: so_clear alone, then coinciding with an overflowing OE pop
        so_clear = 1'b1;
        tick(1);
        so_clear = 1'b0;
        chk("t4_clear_a", 72'({xer_ov, xer_so}), 72'd0);
        chk("t4_cr0_a", 72'(cr0), 72'b1001);
        send(64'h1, 1, 0, 5'd9, 1, 0, 1);
        so_clear = 1'b1;
        tick(1);
        so_clear = 1'b0;
        chk("t4_pop_wins", 72'({xer_ov, xer_so}), 72'b11);
        so_clear = 1'b1;
        tick(1);
        so_clear = 1'b0;
        chk("t4_clear_b", 72'({xer_ov, xer_so}), 72'd0);
        chk("t4_cr0_b", 72'(cr0), 72'b1001);
        // 5: flush a full buffer while a push is attempted
        out_ready = 1'b0;
        send(64'hE, 0, 0, 5'd10, 1, 0, 0);
        send(64'hF, 0, 0, 5'd11, 1, 0, 0);
        chk("t5_full", 72'(in_ready), 72'd0);
        in_result = 64'h6; in_rd = 5'd12; in_valid = 1'b1; flush = 1'b1;
        tick(1);
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("t5_empty", 72'(out_valid), 72'd0);
        chk("t5_ready", 72'(in_ready), 72'd1);
        out_ready = 1'b1;
        tick(2);
        chk("t5_absent", 72'(out_valid), 72'd0);
        chk("t5_cr0", 72'(cr0), 72'b1001);
        // 6: reset mid-operation with two entries buffered
        out_ready = 1'b0;
        send(64'h8000_0000_0000_0000, 1, 0, 5'd13, 1, 1, 1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("t6_pre_cr0", 72'(cr0), 72'b1001);
        send(64'h2, 0, 0, 5'd14, 1, 0, 0);
        send(64'h3, 0, 0, 5'd15, 1, 0, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("t6_outs", 72'({out_valid, out_we, out_rd, out_data}), 72'd0);
        chk("t6_arch", 72'({cr0, xer_ov, xer_so}), 72'd0);
        chk("t6_ready", 72'(in_ready), 72'd1);
        out_ready = 1'b1;
        send(64'h0, 0, 1, 5'd16, 1, 1, 0);
        tick(1);
        chk("t6_cr0_zero", 72'(cr0), 72'b0010);
        chk("queue_empty", 72'(exp_q.size()), 72'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
